// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared interrupt widths and vector type
package intr_pkg;

  localparam int DEF_INTR_WIDTH   = 8;
  localparam int DEF_FILTER_WIDTH = 4;

  typedef logic [DEF_INTR_WIDTH-1:0] intr_vec_t;

endpackage

// File: rtl/intr_cond_line.sv
// rtl/intr_cond_line.sv - one interrupt line: optional sync, glitch filter, rise pulse
// Synchronizer present only with INTR_COND_SYNC_EN defined.
module intr_cond_line
  import intr_pkg::*;
#(
  parameter int FILTER_WIDTH = DEF_FILTER_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    raw_intr,
  input  logic                    cfg_polarity,
  input  logic                    cfg_edge,
  input  logic [FILTER_WIDTH-1:0] cfg_filter_len,
  output logic                    ext_intr,
  output logic                    filt_level
);

  logic                    r_filt;
  logic [FILTER_WIDTH-1:0] r_cnt;
  logic                    r_edge_q;
  logic                    w_src;
  logic                    w_in;
  logic                    w_flip;

`ifdef INTR_COND_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw_intr;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = raw_intr;
`endif

  assign w_in   = w_src ^ cfg_polarity;
  // >= rather than == so a lowered length mid-count still qualifies next edge
  assign w_flip = (w_in != r_filt) && (r_cnt >= cfg_filter_len);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt   <= 1'b0;
      r_cnt    <= '0;
      r_edge_q <= 1'b0;
    end else begin
      r_edge_q <= cfg_edge & w_flip & w_in;
      if (w_in == r_filt) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_filt <= w_in;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + FILTER_WIDTH'(1);
      end
    end
  end

  assign ext_intr   = cfg_edge ? r_edge_q : r_filt;
  assign filt_level = r_filt;

endmodule

// File: rtl/intr_input_conditioner.sv
// rtl/intr_input_conditioner.sv - per-line interrupt conditioning, top level
// Optional input synchronizer selected by INTR_COND_SYNC_EN.
module intr_input_conditioner
  import intr_pkg::*;
#(
  parameter int INTR_WIDTH   = DEF_INTR_WIDTH,
  parameter int FILTER_WIDTH = DEF_FILTER_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INTR_WIDTH-1:0]   raw_intr,
  input  logic [INTR_WIDTH-1:0]   cfg_polarity,
  input  logic [INTR_WIDTH-1:0]   cfg_edge,
  input  logic [FILTER_WIDTH-1:0] cfg_filter_len,
  output logic [INTR_WIDTH-1:0]   ext_intr,
  output logic [INTR_WIDTH-1:0]   filt_level
);

  for (genvar i = 0; i < INTR_WIDTH; i++) begin : g_line
    intr_cond_line #(
      .FILTER_WIDTH(FILTER_WIDTH)
    ) u_line (
      .clk           (clk),
      .reset         (reset),
      .raw_intr      (raw_intr[i]),
      .cfg_polarity  (cfg_polarity[i]),
      .cfg_edge      (cfg_edge[i]),
      .cfg_filter_len(cfg_filter_len),
      .ext_intr      (ext_intr[i]),
      .filt_level    (filt_level[i])
    );
  end

endmodule

// File: tb/tb_intr_input_conditioner.sv
// tb/tb_intr_input_conditioner.sv - scoreboard bench for intr_input_conditioner
module tb_intr_input_conditioner;

  localparam int W  = 8;
  localparam int FW = 4;
`ifdef INTR_COND_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  raw_intr = '0;
  logic [W-1:0]  cfg_polarity = '0;
  logic [W-1:0]  cfg_edge = '0;
  logic [FW-1:0] cfg_filter_len = '0;
  logic [W-1:0]  ext_intr;
  logic [W-1:0]  filt_level;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_s1, m_s2, m_filt, m_edge;
  int           m_run [W];
  logic [2*W-1:0] sb [$];

  always #5 clk = ~clk;

  intr_input_conditioner #(.INTR_WIDTH(W), .FILTER_WIDTH(FW)) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_intr      (raw_intr),
    .cfg_polarity  (cfg_polarity),
    .cfg_edge      (cfg_edge),
    .cfg_filter_len(cfg_filter_len),
    .ext_intr      (ext_intr),
    .filt_level    (filt_level)
  );

  task automatic model_edge();
    logic in_b, nf;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0; m_edge = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        in_b = ((SL != 0) ? m_s2[i] : raw_intr[i]) ^ cfg_polarity[i];
        nf = m_filt[i];
        if (in_b == m_filt[i]) m_run[i] = 0;
        else if (m_run[i] >= int'(cfg_filter_len)) begin nf = in_b; m_run[i] = 0; end
        else m_run[i] = m_run[i] + 1;
        m_edge[i] = cfg_edge[i] & ~m_filt[i] & nf;
        m_filt[i] = nf;
      end
      m_s2 = m_s1;
      m_s1 = raw_intr;
    end
  endtask

  task automatic tick(input string tag);
    logic [2*W-1:0] e;
    model_edge();
    sb.push_back({(cfg_edge & m_edge) | (~cfg_edge & m_filt), m_filt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if (ext_intr !== e[2*W-1:W]) begin
      bad++;
      $display("FAIL %s ext_intr got=%h exp=%h t=%0t", tag, ext_intr, e[2*W-1:W], $time);
    end
    total++;
    if (filt_level !== e[W-1:0]) begin
      bad++;
      $display("FAIL %s filt_level got=%h exp=%h t=%0t", tag, filt_level, e[W-1:0], $time);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick("reset");
    reset = 1'b0;
  endtask

  task automatic test_reset();
    raw_intr = 8'hFF; cfg_polarity = '0; cfg_edge = '0; cfg_filter_len = '0;
    do_reset(3);
    total++;
    if (ext_intr !== '0 || filt_level !== '0) begin
      bad++;
      $display("FAIL reset_state ext=%h filt=%h exp=00", ext_intr, filt_level);
    end
    raw_intr = '0;
    do_reset(1);
  endtask

  task automatic test_level_l0();
    int rise_at = -1, fall_at = -1;
    cfg_filter_len = 0;
    raw_intr[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick("level_l0_rise");
      if (ext_intr[0] && rise_at < 0) rise_at = e;
    end
    raw_intr[0] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick("level_l0_fall");
      if (!ext_intr[0] && fall_at < 0) fall_at = e;
    end
    total++;
    if (rise_at != SL + 1) begin bad++; $display("FAIL level_l0_rise_edge got=%0d exp=%0d", rise_at, SL + 1); end
    total++;
    if (fall_at != SL + 1) begin bad++; $display("FAIL level_l0_fall_edge got=%0d exp=%0d", fall_at, SL + 1); end
  endtask

  task automatic test_glitch();
    int seen = 0, rise_at = -1;
    cfg_filter_len = 3;
    do_reset(1);
    for (int e = 1; e <= 12; e++) begin
      raw_intr[2] = (e <= 3);
      tick("glitch3");
      if (ext_intr[2]) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL glitch3_suppressed got=%0d exp=0", seen); end
    for (int e = 1; e <= 10; e++) begin
      raw_intr[2] = (e <= 4);
      tick("glitch4");
      if (ext_intr[2] && rise_at < 0) rise_at = e;
    end
    total++;
    if (rise_at != SL + 4) begin bad++; $display("FAIL glitch4_rise_edge got=%0d exp=%0d", rise_at, SL + 4); end
    raw_intr = '0;
    do_reset(1);
  endtask

  task automatic test_edge_pulse();
    int pulses = 0, at = -1;
    cfg_filter_len = 1;
    cfg_edge[5] = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      raw_intr[5] = (e <= 20);
      tick("edge_pulse");
      if (ext_intr[5]) begin pulses++; if (at < 0) at = e; end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL edge_pulse_count got=%0d exp=1", pulses); end
    total++;
    if (at != SL + 2) begin bad++; $display("FAIL edge_pulse_edge got=%0d exp=%0d", at, SL + 2); end
    total++;
    if (filt_level[5] !== 1'b0) begin bad++; $display("FAIL edge_filt_fall got=%b exp=0", filt_level[5]); end
    cfg_edge = '0;
    raw_intr = '0;
    do_reset(1);
  endtask

  task automatic test_polarity_reset();
    int rise_at = -1;
    cfg_filter_len = 2;
    cfg_polarity[1] = 1'b1;
    raw_intr[1] = 1'b1;
    do_reset(2);
    for (int e = 1; e <= 4; e++) tick("pol_idle");
    raw_intr[1] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick("pol_rise");
      if (filt_level[1] && rise_at < 0) rise_at = e;
    end
    total++;
    if (rise_at != SL + 3) begin bad++; $display("FAIL pol_rise_edge got=%0d exp=%0d", rise_at, SL + 3); end
    raw_intr[1] = 1'b1;
    for (int e = 1; e <= SL + 2; e++) tick("pol_midcount");
    reset = 1'b1;
    tick("pol_reset");
    total++;
    if (ext_intr !== '0 || filt_level !== '0) begin
      bad++;
      $display("FAIL pol_reset_clear ext=%h filt=%h exp=00", ext_intr, filt_level);
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) tick("pol_raw_high_after");
    total++;
    if (filt_level[1] !== 1'b0) begin bad++; $display("FAIL pol_raw_high_keep got=%b exp=0", filt_level[1]); end
    raw_intr[1] = 1'b0;
    do_reset(1);
    rise_at = -1;
    for (int e = 1; e <= 8; e++) begin
      tick("pol_requal");
      if (filt_level[1] && rise_at < 0) rise_at = e;
    end
    total++;
    if (rise_at != SL + 3) begin bad++; $display("FAIL pol_requal_edge got=%0d exp=%0d", rise_at, SL + 3); end
    cfg_polarity = '0;
    raw_intr = '0;
    do_reset(1);
  endtask

  task automatic test_back_to_back();
    cfg_edge = 8'b1010_0110;
    cfg_polarity = 8'b0011_0101;
    cfg_filter_len = 1;
    do_reset(1);
    raw_intr = 8'hFF;
    for (int e = 1; e <= 8; e++) tick("all_lines_toggle_hi");
    raw_intr = 8'h00;
    for (int e = 1; e <= 8; e++) tick("all_lines_toggle_lo");
    for (int e = 0; e < 120; e++) begin
      if (e % 7 == 0) raw_intr = W'($urandom);
      else raw_intr = raw_intr ^ W'($urandom_range(0, 1) << $urandom_range(0, W - 1));
      if (e == 40) cfg_filter_len = 0;
      if (e == 60) cfg_polarity = W'($urandom);
      if (e == 80) cfg_edge = W'($urandom);
      if (e == 95) cfg_filter_len = 3;
      tick("random_mixed");
    end
  endtask

  initial begin
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_s1 = '0; m_s2 = '0; m_filt = '0; m_edge = '0;
    test_reset();
    test_level_l0();
    test_glitch();
    test_edge_pulse();
    test_polarity_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
